// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB bus arbiter: transfer encodings, arbiter
// states and the master count.
package bridge_pkg;

    localparam int NUM_MASTERS = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } arb_state_e;

    function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signal bundle of the arbiter: requests and transfer status in,
// grant and ownership information out.
interface ahb_bus_arbiter_if;
    import bridge_pkg::*;

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic [1:0]             htrans;
    logic                   hreadyin;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [1:0]             hmaster;
    logic [1:0]             hmaster_data;
    logic                   hmastlock;

    modport slave (
        input  hbusreq, hlock, htrans, hreadyin,
        output hgrant, hmaster, hmaster_data, hmastlock
    );

    modport master (
        output hbusreq, hlock, htrans, hreadyin,
        input  hgrant, hmaster, hmaster_data, hmastlock
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first asserted request searching upward from the
// master after the last owner, wrapping around.
module rr_pick
    import bridge_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [1:0]             i_last,
    output logic [1:0]             o_winner,
    output logic                   o_valid
);

    function automatic logic [1:0] wrap_add(input logic [1:0] base, input int k);
        return 2'((int'(base) + k) % NUM_MASTERS);
    endfunction

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        o_winner = 2'd0;
        o_valid  = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (i_req[wrap_add(i_last, k)]) begin
                o_winner = wrap_add(i_last, k);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Three-master AHB arbiter with round-robin selection, per-tenure beat quota
// and locked tenures; grant decisions take effect one cycle after the point.
module ahb_bus_arbiter
    import bridge_pkg::*;
#(
    parameter int QUOTA = 4
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_bus_arbiter_if.slave  bus
);

    localparam logic [3:0] LP_QUOTA = 4'(QUOTA);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [1:0]             r_hmaster;
    logic [1:0]             r_hmaster_data;
    logic                   r_hmastlock;
    logic [3:0]             r_beat_cnt;

    arb_state_e             w_state_nxt;
    logic [1:0]             w_owner_nxt;
    logic [3:0]             w_cnt_nxt;
    logic [3:0]             w_cnt_sat;
    logic                   w_arb_point;
    logic                   w_beat;
    logic                   w_owner_req;
    logic                   w_owner_lock;
    logic                   w_others_req;
    logic                   w_quota_hit;
    logic [1:0]             w_rr_winner;
    logic                   w_rr_valid;

    rr_pick u_rr_pick (
        .i_req    (bus.hbusreq),
        .i_last   (r_hmaster),
        .o_winner (w_rr_winner),
        .o_valid  (w_rr_valid)
    );

    // BUSY and IDLE are arbitration points; only NONSEQ/SEQ count as beats.
    assign w_arb_point  = bus.hreadyin && (bus.htrans != HTRANS_SEQ);
    assign w_beat       = bus.hreadyin && bus.htrans[1];
    assign w_owner_req  = bus.hbusreq[r_hmaster];
    assign w_owner_lock = bus.hlock[r_hmaster];
    assign w_others_req = |(bus.hbusreq & ~idx_to_onehot(r_hmaster));
    assign w_quota_hit  = (r_beat_cnt == LP_QUOTA);
    assign w_cnt_sat    = (r_beat_cnt >= LP_QUOTA) ? LP_QUOTA : r_beat_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_hmaster;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            ST_PARK: begin
                w_cnt_nxt = 4'd0;
                if (w_arb_point && w_rr_valid) begin
                    w_owner_nxt = w_rr_winner;
                    w_state_nxt = bus.hlock[w_rr_winner] ? ST_LOCK : ST_OWN;
                end
            end
            ST_OWN, ST_LOCK: begin
                if (w_beat) begin
                    w_cnt_nxt = w_cnt_sat;
                end
                if (w_arb_point) begin
                    // A held lock outranks quota expiry.
                    if (w_owner_lock && w_owner_req) begin
                        w_state_nxt = ST_LOCK;
                    end else if (!w_owner_req || (w_quota_hit && w_others_req)) begin
                        w_cnt_nxt = 4'd0;
                        if (w_rr_valid) begin
                            w_owner_nxt = w_rr_winner;
                            w_state_nxt = bus.hlock[w_rr_winner] ? ST_LOCK : ST_OWN;
                        end else begin
                            w_owner_nxt = 2'd0;
                            w_state_nxt = ST_PARK;
                        end
                    end else begin
                        w_state_nxt = ST_OWN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_PARK;
                w_owner_nxt = 2'd0;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state        <= ST_PARK;
            r_hgrant       <= 3'b001;
            r_hmaster      <= 2'd0;
            r_hmaster_data <= 2'd0;
            r_hmastlock    <= 1'b0;
            r_beat_cnt     <= 4'd0;
        end else if (bus.hreadyin) begin
            r_state        <= w_state_nxt;
            r_hmaster      <= w_owner_nxt;
            r_hgrant       <= idx_to_onehot(w_owner_nxt);
            r_hmaster_data <= r_hmaster;
            r_hmastlock    <= (w_state_nxt == ST_LOCK);
            r_beat_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.hgrant       = r_hgrant;
    assign bus.hmaster      = r_hmaster;
    assign bus.hmaster_data = r_hmaster_data;
    assign bus.hmastlock    = r_hmastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed scenarios plus random traffic on two arbiters (QUOTA 4 and 1),
// both checked every cycle against a rule-level reference model.
module tb_ahb_bus_arbiter;
    import bridge_pkg::*;

    typedef struct {
        bit park;
        bit lock;
        int owner;
        int cnt;
        int data;
        bit mlock;
    } mdl_t;

    logic hclk = 1'b0;
    logic hreset;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    mdl_t m4;
    mdl_t m1;

    always #5 hclk = ~hclk;

    ahb_bus_arbiter_if bus4 ();
    ahb_bus_arbiter_if bus1 ();

    ahb_bus_arbiter #(.QUOTA(4)) dut4 (.hclk(hclk), .hreset(hreset), .bus(bus4.slave));
    ahb_bus_arbiter #(.QUOTA(1)) dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1.slave));

    function automatic int rr_next(int last, logic [2:0] req);
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, int q, logic rst, logic [2:0] req,
                                      logic [2:0] lk, logic [1:0] tr, logic rdy);
        mdl_t n;
        int   win;
        bit   handover;
        int   bumped;
        n = s;
        handover = 1'b0;
        bumped = (s.cnt < q) ? s.cnt + 1 : q;
        if (rst) begin
            n.park = 1'b1; n.lock = 1'b0; n.owner = 0;
            n.cnt = 0; n.data = 0; n.mlock = 1'b0;
            return n;
        end
        if (!rdy) return n;
        n.data = s.owner;
        if (tr == 2'b11) begin
            if (!s.park) n.cnt = bumped;
        end else if (s.park) begin
            handover = (req != 3'b000);
        end else if (lk[s.owner] && req[s.owner]) begin
            n.lock = 1'b1;
            if (tr[1]) n.cnt = bumped;
        end else if (!req[s.owner] || (s.cnt == q && (req & ~(3'b001 << s.owner)) != 3'b000)) begin
            handover = 1'b1;
        end else begin
            n.lock = 1'b0;
            if (tr[1]) n.cnt = bumped;
        end
        if (handover) begin
            win = rr_next(s.owner, req);
            n.cnt = 0;
            if (win < 0) begin
                n.park = 1'b1; n.owner = 0; n.lock = 1'b0;
            end else begin
                n.park = 1'b0; n.owner = win; n.lock = lk[win];
            end
        end
        n.mlock = n.lock;
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s @step %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag, mdl_t m, logic [2:0] g, logic [1:0] hm,
                                 logic [1:0] hd, logic ml, logic [3:0] cnt);
        check({tag, "_hgrant"}, 32'(g), 32'(3'b001 << m.owner));
        check({tag, "_hmaster"}, 32'(hm), 32'(m.owner));
        check({tag, "_hmaster_data"}, 32'(hd), 32'(m.data));
        check({tag, "_hmastlock"}, 32'(ml), 32'(m.mlock));
        check({tag, "_beat_cnt"}, 32'(cnt), 32'(m.cnt));
        check({tag, "_grant_matches_master"}, 32'(g), 32'(3'b001 << hm));
    endtask

    task automatic step(logic rst, logic [2:0] req, logic [2:0] lk, logic [1:0] tr, logic rdy);
        hreset        = rst;
        bus4.hbusreq  = req; bus4.hlock = lk; bus4.htrans = tr; bus4.hreadyin = rdy;
        bus1.hbusreq  = req; bus1.hlock = lk; bus1.htrans = tr; bus1.hreadyin = rdy;
        @(posedge hclk);
        #1;
        cyc++;
        m4 = mdl_step(m4, 4, rst, req, lk, tr, rdy);
        m1 = mdl_step(m1, 1, rst, req, lk, tr, rdy);
        check_outputs("q4", m4, bus4.hgrant, bus4.hmaster, bus4.hmaster_data,
                      bus4.hmastlock, dut4.r_beat_cnt);
        check_outputs("q1", m1, bus1.hgrant, bus1.hmaster, bus1.hmaster_data,
                      bus1.hmastlock, dut1.r_beat_cnt);
    endtask

    initial begin
        logic [2:0] req;
        logic [2:0] lk;
        int         rot [3];
        rot = '{1, 2, 0};

        // Idle bus after reset: master 0 parked.
        step(1'b1, 3'b000, 3'b000, HTRANS_IDLE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'b000, 3'b000, HTRANS_IDLE, 1'b1);
            check("s1_hgrant", 32'(bus4.hgrant), 32'h1);
            check("s1_hmaster", 32'(bus4.hmaster), 32'h0);
            check("s1_hmastlock", 32'(bus4.hmastlock), 32'h0);
        end

        // Quota expiry hands master 1 over to master 2.
        step(1'b1, 3'b000, 3'b000, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b110, 3'b000, HTRANS_IDLE, 1'b1);
        check("s2_first_grant", 32'(bus4.hgrant), 32'h2);
        step(1'b0, 3'b110, 3'b000, HTRANS_NONSEQ, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'b110, 3'b000, HTRANS_SEQ, 1'b1);
            check("s2_burst_grant", 32'(bus4.hgrant), 32'h2);
        end
        step(1'b0, 3'b110, 3'b000, HTRANS_IDLE, 1'b1);
        check("s2_handover_grant", 32'(bus4.hgrant), 32'h4);
        check("s2_data_old", 32'(bus4.hmaster_data), 32'h1);
        step(1'b0, 3'b110, 3'b000, HTRANS_IDLE, 1'b1);
        check("s2_data_new", 32'(bus4.hmaster_data), 32'h2);

        // Locked tenure ignores quota; unlock wraps to master 0.
        step(1'b1, 3'b000, 3'b000, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b100, 3'b100, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b111, 3'b100, HTRANS_NONSEQ, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 3'b111, 3'b100, HTRANS_SEQ, 1'b1);
            check("s3_lock_grant", 32'(bus4.hgrant), 32'h4);
            check("s3_lock_mastlock", 32'(bus4.hmastlock), 32'h1);
        end
        step(1'b0, 3'b111, 3'b000, HTRANS_IDLE, 1'b1);
        check("s3_unlock_grant", 32'(bus4.hgrant), 32'h1);
        check("s3_unlock_mastlock", 32'(bus4.hmastlock), 32'h0);

        // Wait states freeze everything while requests change.
        step(1'b1, 3'b000, 3'b000, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b001, 3'b000, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b001, 3'b000, HTRANS_IDLE, 1'b0);
        step(1'b0, 3'b010, 3'b000, HTRANS_IDLE, 1'b0);
        step(1'b0, 3'b010, 3'b000, HTRANS_NONSEQ, 1'b0);
        check("s4_frozen_grant", 32'(bus4.hgrant), 32'h1);
        check("s4_frozen_data", 32'(bus4.hmaster_data), 32'h0);
        step(1'b0, 3'b010, 3'b000, HTRANS_IDLE, 1'b1);
        check("s4_handover", 32'(bus4.hgrant), 32'h2);

        // Reset in the middle of a locked burst.
        step(1'b1, 3'b000, 3'b000, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b100, 3'b100, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b100, 3'b100, HTRANS_NONSEQ, 1'b1);
        step(1'b0, 3'b100, 3'b100, HTRANS_SEQ, 1'b1);
        step(1'b0, 3'b100, 3'b100, HTRANS_SEQ, 1'b1);
        check("s5_cnt_before", 32'(dut4.r_beat_cnt), 32'h3);
        step(1'b1, 3'b100, 3'b100, HTRANS_SEQ, 1'b1);
        check("s5_rst_grant", 32'(bus4.hgrant), 32'h1);
        check("s5_rst_mastlock", 32'(bus4.hmastlock), 32'h0);
        check("s5_rst_data", 32'(bus4.hmaster_data), 32'h0);
        step(1'b0, 3'b010, 3'b000, HTRANS_IDLE, 1'b1);
        check("s5_regrant", 32'(bus4.hgrant), 32'h2);
        check("s5_cnt_after", 32'(dut4.r_beat_cnt), 32'h0);

        // QUOTA=1: idle owners keep the bus, one beat per tenure rotates it.
        step(1'b1, 3'b000, 3'b000, HTRANS_IDLE, 1'b1);
        step(1'b0, 3'b001, 3'b000, HTRANS_IDLE, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'b111, 3'b000, HTRANS_IDLE, 1'b1);
            check("s6_idle_hold", 32'(bus1.hmaster), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b111, 3'b000, HTRANS_NONSEQ, 1'b1);
            step(1'b0, 3'b111, 3'b000, HTRANS_IDLE, 1'b1);
            check("s6_rotate", 32'(bus1.hmaster), 32'(rot[i]));
        end

        // Random traffic with sticky requests and locks.
        req = 3'b000;
        lk  = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) lk  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            step(($urandom_range(0, 59) == 0), req, lk, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 The block SHALL have parameter QUOTA, default 4: maximum beats per tenure before forced re-arbitration; legal range 1..15.
REQ-002 Port hclk SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port hreset SHALL be: input, 1 bit, reset, synchronous and active-high.
REQ-004 Port hbusreq SHALL be: input, 3 bits, bus request, one bit per master 0..2.
REQ-005 Port hlock SHALL be: input, 3 bits, locked-transfer request per master.
REQ-006 Port htrans SHALL be: input, 2 bits, transfer type of the currently granted master, as seen at the bridge.
REQ-007 Port hreadyin SHALL be: input, 1 bit, bridge ready; 1 = current address phase accepted.
REQ-008 Port hgrant SHALL be: output, 3 bits, one-hot grant.
REQ-009 Port hmaster SHALL be: output, 2 bits, index of the address-phase owner.
REQ-010 Port hmaster_data SHALL be: output, 2 bits, index of the data-phase owner.
REQ-011 Port hmastlock SHALL be: output, 1 bit, current tenure is locked.

Function
REQ-012 The FSM SHALL have three states: PARK (no requester, master 0 parked), OWN (unlocked tenure) and LOCK (locked tenure).
REQ-013 An arbitration point SHALL be any cycle with hreadyin=1 and htrans not SEQ (2'b11).
REQ-014 When hreadyin=0, all state SHALL hold: FSM, hgrant, hmaster, hmaster_data, hmastlock and beat count.
REQ-015 Round-robin selection SHALL search from (owner+1) mod 3 upward, wrapping, and pick the first asserted hbusreq bit.
REQ-016 In PARK, any arbitration point with a nonzero hbusreq SHALL grant the round-robin winner and enter OWN, or LOCK if that master's hlock=1.
REQ-017 In OWN, handover SHALL occur at an arbitration point when hbusreq[owner]=0, or when beat count = QUOTA and another master requests.
REQ-018 In OWN with no other requester, the owner SHALL keep the grant past QUOTA, with the beat count held saturated.
REQ-019 If no master requests at a handover point, the block SHALL enter PARK with hgrant=001 and hmaster=0.
REQ-020 LOCK SHALL be retained while hlock[owner]=1 and hbusreq[owner]=1, regardless of quota.
REQ-021 LOCK SHALL be left at the first arbitration point where hlock[owner]=0, then handled per REQ-017/REQ-019.
REQ-022 If quota expiry and an asserted hlock of the owner coincide, lock SHALL take precedence.
REQ-023 A grant change decided at an arbitration point SHALL be visible on hgrant and hmaster on the next cycle (latency 1).
REQ-024 hgrant SHALL always be one-hot and SHALL always encode the same master as hmaster.
REQ-025 The beat count SHALL be 4 bits; it SHALL increment when hreadyin=1 and htrans[1]=1, saturate at QUOTA, and clear to 0 on every ownership change.
REQ-026 hmaster_data SHALL load hmaster when hreadyin=1.
REQ-027 hmastlock SHALL load (state LOCK after the update) when hreadyin=1.
REQ-028 BUSY (2'b01) SHALL not count as a beat and SHALL be a legal arbitration point.

Reset
REQ-029 When hreset=1 at a clock edge, the block SHALL force PARK, hgrant=001, hmaster=0, hmaster_data=0, hmastlock=0 and beat count=0, overriding hreadyin and all requests, including mid-burst and mid-lock.
REQ-030 The first arbitration after reset is released SHALL search from master 1.

Structure
REQ-031 Shared package bridge_pkg SHALL hold the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), the FSM state enumeration and the constant NUM_MASTERS=3.
REQ-032 The round-robin search SHALL be one combinational sub-module, rr_pick: inputs request vector and last owner; outputs winner index and valid.

Verification
REQ-033 Scenario 1: assert reset, release, hbusreq=000 for 5 cycles -> hgrant=001, hmaster=0 and hmastlock=0 throughout.
REQ-034 Scenario 2: hbusreq=110, hreadyin=1, master 1 issues NONSEQ then SEQ continuously, QUOTA=4 -> after the 4th counted beat, hgrant switches 010->100 one cycle after the first non-SEQ cycle, and hmaster_data follows one accepted phase later.
REQ-035 Scenario 3: master 2 owns with hlock=100, hbusreq=111, 10 SEQ beats -> hgrant stays 100 and hmastlock=1; drop hlock, send IDLE -> grant goes to master 0 (wrap), and hmastlock=0.
REQ-036 Scenario 4: hreadyin=0 for 3 cycles while hbusreq changes 001->010 -> all outputs frozen; hreadyin=1 with IDLE -> handover to master 1.
REQ-037 Scenario 5: assert reset mid-LOCK with beat count 3 -> next cycle hgrant=001, hmaster=0, hmaster_data=0, hmastlock=0; beat count observed as 0 after the next grant.
REQ-038 Scenario 6: hbusreq=111 held with IDLE at every cycle, QUOTA=1, and each owner keeping its request -> the owner does not change, since the beat count stays 0; then issue one NONSEQ per tenure -> grant rotates 0->1->2->0.
